frac_ratio_gen: RTL and testbench

//  - Ratio-word producer for the dual-modulus divider. It drives Pi/Si into the p_counter/s_counter pair.
//  - Runs a MASH 1-1-1 sigma-delta modulator that steps once per divider output period, on the LDo pulse from p_counter.
//  - Emits the instantaneous ratio N = N_int + dither and splits it into P = N >> S_WIDTH and S = N mod 2^S_WIDTH.
//  - The long-run mean of N is N_int + K_frac/2^F_WIDTH.

---
 rtl/frac_div_pkg.sv | 29 ++
 rtl/frac_ratio_gen_if.sv | 26 ++
 rtl/frac_ratio_gen_mash_stage.sv | 33 +++
 rtl/frac_ratio_gen.sv | 184 ++++++++++++++++++
 tb/tb_frac_ratio_gen.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/frac_div_pkg.sv
// Shared widths, types and constants for the fractional ratio generator.
// Build option FRAC_LSB_DITHER_EN adds an LFSR LSB dither into the MASH input.
package frac_div_pkg;

    localparam int P_WIDTH  = 5;
    localparam int S_WIDTH  = 3;
    localparam int F_WIDTH  = 8;
    localparam int R_WIDTH  = P_WIDTH + S_WIDTH;
    localparam int NMIN_DEF = 16;
    localparam int NMAX_DEF = 255;
    localparam int LFSR_W   = 15;

    typedef logic [R_WIDTH-1:0]        ratio_t;
    typedef logic signed [3:0]         dither_t;
    typedef logic [F_WIDTH-1:0]        frac_t;
    typedef logic [P_WIDTH-1:0]        p_t;
    typedef logic [S_WIDTH-1:0]        s_t;
    typedef logic signed [R_WIDTH+1:0] nwide_t;

    localparam dither_t DITHER_MIN = -4'sd3;
    localparam dither_t DITHER_MAX = 4'sd4;

    localparam logic [LFSR_W-1:0] LFSR_SEED = 15'h0001;

    function automatic dither_t to_d(input logic b);
        return dither_t'({3'b000, b});
    endfunction

endpackage

// File: rtl/frac_ratio_gen_if.sv
// Control/ratio bundle between the divider control side and the generator.
// Master drives the ratio request, slave returns the P/S presets.
interface frac_ratio_gen_if
    import frac_div_pkg::*;
();

    logic   en;
    logic   LDi;
    ratio_t N_int;
    frac_t  K_frac;
    p_t     Po;
    s_t     So;
    logic   upd;
    logic   sat;

    modport master (
        output en, LDi, N_int, K_frac,
        input  Po, So, upd, sat
    );

    modport slave (
        input  en, LDi, N_int, K_frac,
        output Po, So, upd, sat
    );

endinterface

// File: rtl/frac_ratio_gen_mash_stage.sv
// One first-order MASH section: F_WIDTH accumulator with carry out.
// sum/carry are the next-state value, so stages chain in one cycle.
module mash_stage
    import frac_div_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  step,
    input  frac_t inc,
    input  logic  cin,
    output frac_t sum,
    output logic  carry
);

    frac_t acc_q;
    frac_t acc_d;

    always_comb begin
        {carry, sum} = {1'b0, acc_q}
                     + {1'b0, inc}
                     + {{F_WIDTH{1'b0}}, cin};
        acc_d = step ? sum : acc_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/frac_ratio_gen.sv
// MASH 1-1-1 ratio generator: N = N_int + dither, split into P/S presets.
// Define FRAC_LSB_DITHER_EN to add a 15-bit LFSR LSB dither on acc1.
module frac_ratio_gen
    import frac_div_pkg::*;
#(
    parameter int NMIN = NMIN_DEF,
    parameter int NMAX = NMAX_DEF
)
(
    input logic              Fin,
    input logic              rst,
    frac_ratio_gen_if.slave  bus
);

    localparam ratio_t NMIN_R = ratio_t'(NMIN);
    localparam ratio_t NMAX_R = ratio_t'(NMAX);
    localparam nwide_t NMIN_W = nwide_t'(NMIN);
    localparam nwide_t NMAX_W = nwide_t'(NMAX);

    logic    step;
    logic    cin;
    frac_t   s1, s2, s3;
    logic    c1, c2, c3;
    dither_t y;
    logic    unused_s3;

    logic    c2_dly_q, c2_dly_d;
    logic    c3_dly_q, c3_dly_d;
    logic    c3_dly2_q, c3_dly2_d;

    nwide_t  n_q, n_d;
    logic    pend_q, pend_d;

    p_t      po_q, po_d;
    s_t      so_q, so_d;
    logic    upd_q, upd_d;
    logic    sat_q, sat_d;
    ratio_t  r;
    logic    clip;

    assign step      = bus.LDi & bus.en;
    assign unused_s3 = ^s3;

`ifdef FRAC_LSB_DITHER_EN
    logic [LFSR_W-1:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (step) begin
            lfsr_d = {lfsr_q[13:0], lfsr_q[14] ^ lfsr_q[13]};
        end
    end

    always_ff @(posedge Fin) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign cin = lfsr_q[0];
`else
    assign cin = 1'b0;
`endif

    mash_stage u_st1 (
        .clk   (Fin),
        .rst   (rst),
        .step  (step),
        .inc   (bus.K_frac),
        .cin   (cin),
        .sum   (s1),
        .carry (c1)
    );

    mash_stage u_st2 (
        .clk   (Fin),
        .rst   (rst),
        .step  (step),
        .inc   (s1),
        .cin   (1'b0),
        .sum   (s2),
        .carry (c2)
    );

    mash_stage u_st3 (
        .clk   (Fin),
        .rst   (rst),
        .step  (step),
        .inc   (s2),
        .cin   (1'b0),
        .sum   (s3),
        .carry (c3)
    );

    // Noise shaping: c1 + d(c2) + d2(c3), range DITHER_MIN..DITHER_MAX
    always_comb begin
        y = '0;
        if (bus.en) begin
            y = to_d(c1)
              + to_d(c2) - to_d(c2_dly_q)
              + to_d(c3) - to_d(c3_dly_q) - to_d(c3_dly_q)
              + to_d(c3_dly2_q);
        end
    end

    always_comb begin
        c2_dly_d  = c2_dly_q;
        c3_dly_d  = c3_dly_q;
        c3_dly2_d = c3_dly2_q;
        if (step) begin
            c2_dly_d  = c2;
            c3_dly_d  = c3;
            c3_dly2_d = c3_dly_q;
        end
    end

    always_comb begin
        n_d    = n_q;
        pend_d = bus.LDi;
        if (bus.LDi) begin
            n_d = nwide_t'({2'b00, bus.N_int}) + nwide_t'(y);
        end
    end

    always_ff @(posedge Fin) begin
        if (rst) begin
            c2_dly_q  <= 1'b0;
            c3_dly_q  <= 1'b0;
            c3_dly2_q <= 1'b0;
            n_q       <= '0;
            pend_q    <= 1'b0;
        end else begin
            c2_dly_q  <= c2_dly_d;
            c3_dly_q  <= c3_dly_d;
            c3_dly2_q <= c3_dly2_d;
            n_q       <= n_d;
            pend_q    <= pend_d;
        end
    end

    // Clamp into the legal dual-modulus range, then split to P/S
    always_comb begin
        r     = n_q[R_WIDTH-1:0];
        clip  = 1'b0;
        if (n_q < NMIN_W) begin
            r    = NMIN_R;
            clip = 1'b1;
        end else if (n_q > NMAX_W) begin
            r    = NMAX_R;
            clip = 1'b1;
        end
        po_d  = po_q;
        so_d  = so_q;
        sat_d = sat_q;
        upd_d = pend_q;
        if (pend_q) begin
            po_d  = r[R_WIDTH-1:S_WIDTH];
            so_d  = r[S_WIDTH-1:0];
            sat_d = sat_q | clip;
        end
    end

    always_ff @(posedge Fin) begin
        if (rst) begin
            po_q  <= NMIN_R[R_WIDTH-1:S_WIDTH];
            so_q  <= NMIN_R[S_WIDTH-1:0];
            upd_q <= 1'b0;
            sat_q <= 1'b0;
        end else begin
            po_q  <= po_d;
            so_q  <= so_d;
            upd_q <= upd_d;
            sat_q <= sat_d;
        end
    end

    assign bus.Po  = po_q;
    assign bus.So  = so_q;
    assign bus.upd = upd_q;
    assign bus.sat = sat_q;

endmodule

// File: tb/tb_frac_ratio_gen.sv
// Self-checking bench for frac_ratio_gen: vector table, corner sequences,
// and randomized updates against an arithmetic MASH reference model.
module tb_frac_ratio_gen;

    logic Fin = 1'b0;
    logic rst;

    frac_ratio_gen_if bus ();

    frac_ratio_gen dut (
        .Fin (Fin),
        .rst (rst),
        .bus (bus)
    );

    always #5 Fin = ~Fin;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: plain integers, wrap at 256
    int m_a1, m_a2, m_a3;
    int m_c2p, m_c3p, m_c3pp;
    int m_sat;
    int m_lfsr;

    typedef struct {
        bit en;
        int nint;
        int k;
        int po;
        int so;
        int sat;
    } vec_t;

    vec_t tab[6];

    task automatic check(input string name, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic model_reset();
        m_a1 = 0; m_a2 = 0; m_a3 = 0;
        m_c2p = 0; m_c3p = 0; m_c3pp = 0;
        m_sat = 0;
        m_lfsr = 1;
    endtask

    task automatic model_step(input bit e, input int nint, input int k,
                              output int n);
        int s, c1, c2, c3, y, kin, fb;
        y = 0;
        if (e) begin
            kin = k;
`ifdef FRAC_LSB_DITHER_EN
            kin = kin + (m_lfsr & 1);
            fb = ((m_lfsr >> 14) ^ (m_lfsr >> 13)) & 1;
            m_lfsr = ((m_lfsr << 1) | fb) & 32'h7fff;
`else
            fb = 0;
`endif
            s = m_a1 + kin; c1 = s / 256; m_a1 = s % 256;
            s = m_a2 + m_a1; c2 = s / 256; m_a2 = s % 256;
            s = m_a3 + m_a2; c3 = s / 256; m_a3 = s % 256;
            y = c1 + (c2 - m_c2p) + (c3 - 2 * m_c3p + m_c3pp);
            m_c2p = c2;
            m_c3pp = m_c3p;
            m_c3p = c3;
        end
        n = nint + y;
        if (n < 16) begin
            n = 16; m_sat = 1;
        end else if (n > 255) begin
            n = 255; m_sat = 1;
        end
    endtask

    // One update: LDi for one cycle, sample two edges later, then idle
    task automatic do_upd(input bit e, input int nint, input int k,
                          input int gap,
                          output int n, output int up, output int sa,
                          output int up_after);
        @(negedge Fin);
        bus.en = e;
        bus.N_int = nint[7:0];
        bus.K_frac = k[7:0];
        bus.LDi = 1'b1;
        @(negedge Fin);
        bus.LDi = 1'b0;
        @(negedge Fin);
        n = int'(bus.Po) * 8 + int'(bus.So);
        up = int'(bus.upd);
        sa = int'(bus.sat);
        @(negedge Fin);
        up_after = int'(bus.upd);
        repeat (gap - 4) @(negedge Fin);
    endtask

    task automatic run_upd(input string name, input bit e, input int nint,
                           input int k, input int gap, output int n);
        int exp_n, up, sa, ua;
        do_upd(e, nint, k, gap, n, up, sa, ua);
        model_step(e, nint, k, exp_n);
        check({name, "_N"}, n, exp_n);
        check({name, "_upd"}, up, 1);
        check({name, "_sat"}, sa, m_sat);
    endtask

    task automatic do_reset();
        @(negedge Fin);
        rst = 1'b1;
        bus.LDi = 1'b0;
        @(negedge Fin);
        @(negedge Fin);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int n, up, sa, ua, sum, lo, hi, nz, exp_n;
        int q[$];

        rst = 1'b1;
        bus.en = 1'b1;
        bus.LDi = 1'b0;
        bus.N_int = '0;
        bus.K_frac = '0;
        model_reset();

        tab[0] = '{1'b1, 59, 0, 7, 3, 0};
        tab[1] = '{1'b1, 16, 0, 2, 0, 0};
        tab[2] = '{1'b1, 255, 0, 31, 7, 0};
        tab[3] = '{1'b0, 100, 77, 12, 4, 0};
        tab[4] = '{1'b1, 130, 0, 16, 2, 0};
        tab[5] = '{1'b1, 10, 0, 2, 0, 1};

        repeat (3) @(negedge Fin);
        rst = 1'b0;
        @(negedge Fin);
        check("rst_Po", int'(bus.Po), 2);
        check("rst_So", int'(bus.So), 0);
        check("rst_upd", int'(bus.upd), 0);
        check("rst_sat", int'(bus.sat), 0);

        foreach (tab[i]) begin
            do_upd(tab[i].en, tab[i].nint, tab[i].k, 20, n, up, sa, ua);
            model_step(tab[i].en, tab[i].nint, tab[i].k, exp_n);
            check($sformatf("vec%0d_Po", i), n / 8, tab[i].po);
            check($sformatf("vec%0d_So", i), n % 8, tab[i].so);
            check($sformatf("vec%0d_upd", i), up, 1);
            check($sformatf("vec%0d_upd_clr", i), ua, 0);
            check($sformatf("vec%0d_sat", i), sa, tab[i].sat);
        end

        // Half fraction: mean 59.5 over 256 periods
        do_reset();
        sum = 0; lo = 999; hi = -1;
        for (int i = 0; i < 256; i++) begin
            run_upd("half", 1'b1, 59, 128, 20, n);
            sum += n;
            if (n < lo) lo = n;
            if (n > hi) hi = n;
        end
        check("half_sum", sum, 15232);
        check("half_range", int'(lo >= 56 && hi <= 63), 1);

        // Clamp near NMIN
        do_reset();
        lo = 999;
        for (int i = 0; i < 64; i++) begin
            run_upd("clamp", 1'b1, 17, 200, 20, n);
            if (n < lo) lo = n;
        end
        check("clamp_min", int'(lo >= 16), 1);
        check("clamp_sat", int'(bus.sat), m_sat);

        // Reset colliding with LDi: no update, outputs back to reset
        @(negedge Fin);
        bus.en = 1'b1;
        bus.N_int = 8'd200;
        bus.K_frac = 8'd33;
        bus.LDi = 1'b1;
        rst = 1'b1;
        @(negedge Fin);
        rst = 1'b0;
        bus.LDi = 1'b0;
        model_reset();
        check("coll_Po", int'(bus.Po), 2);
        check("coll_So", int'(bus.So), 0);
        check("coll_upd", int'(bus.upd), 0);
        check("coll_sat", int'(bus.sat), 0);
        @(negedge Fin);
        check("coll_upd2", int'(bus.upd), 0);
        run_upd("coll_after", 1'b1, 90, 77, 20, n);

        // Freeze and resume
        do_reset();
        for (int i = 0; i < 5; i++) run_upd("pre", 1'b1, 90, 77, 20, n);
        for (int i = 0; i < 10; i++) begin
            run_upd("frz", 1'b0, 90, 77, 20, n);
            check("frz_Nint", n, 90);
        end
        for (int i = 0; i < 10; i++) run_upd("resume", 1'b1, 90, 77, 20, n);

        // Back-to-back LDi: every strobe is its own update
        do_reset();
        for (int i = 0; i < 3; i++) begin
            model_step(1'b1, 40 + i, 90, exp_n);
            q.push_back(exp_n);
        end
        bus.en = 1'b1;
        bus.K_frac = 8'd90;
        for (int i = 0; i < 5; i++) begin
            bus.LDi = (i < 3);
            bus.N_int = 8'(40 + i);
            @(negedge Fin);
            if (i >= 1 && i <= 3) begin
                check("b2b_upd", int'(bus.upd), 1);
                check("b2b_N", int'(bus.Po) * 8 + int'(bus.So),
                      q.pop_front());
            end
        end
        check("b2b_upd_clr", int'(bus.upd), 0);

        // Randomized updates against the model
        do_reset();
        for (int i = 0; i < 150; i++) begin
            run_upd("rnd", 1'($urandom_range(0, 3) != 0),
                    int'($urandom_range(14, 254)),
                    int'($urandom_range(0, 255)), 20, n);
        end

`ifdef FRAC_LSB_DITHER_EN
        do_reset();
        sum = 0; nz = 0;
        for (int i = 0; i < 4096; i++) begin
            run_upd("dith", 1'b1, 100, 0, 4, n);
            sum += n;
            if (n != 100) nz++;
        end
        check("dith_nz", int'(nz > 0), 1);
        check("dith_mean", int'(sum >= 409600 - 40 && sum <= 409600 + 40), 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
